pipeline_hazard_ctrl: RTL and testbench

Central hazard and sequencing controller for the 5-stage pipeline (IF, ID, EX, MEM, WB). It keeps shadow copies of the destination register and write-enable for EX, MEM and WB, and from them drives:
- load-use stalls: PC enable, IF_ID enable, and the select of the control-signal NOP multiplexer;
- branch flushes of IF_ID;
- operand forwarding selects;
- a full pipeline freeze while data memory is not ready, with a timeout.

---
 rtl/pipeline_hazard_ctrl.sv | 128 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use stall, branch flush, forwarding and memory-wait freeze for a 5-stage pipeline.
// Optional saturating performance counters are enabled with HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       id_rn,
    input  logic [3:0]       id_rm,
    input  logic [3:0]       id_rd,
    input  logic             id_use_rn,
    input  logic             id_use_rm,
    input  logic             id_use_rd,
    input  logic [3:0]       id_dst,
    input  logic             id_rf_e,
    input  logic             id_load,
    input  logic             id_b_taken,
    input  logic             mem_e,
    input  logic             mem_ready,
    output logic             pc_e,
    output logic             if_id_e,
    output logic             if_id_flush,
    output logic             nop_sel,
    output logic             pipe_hold,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       fwd_c,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt
);
    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t          state;
    logic [WC_W-1:0] wcnt;
    logic [3:0]      ex_dst, mem_dst, wb_dst;
    logic            ex_rf_e, ex_load, mem_rf_e, mem_load, wb_rf_e;
    logic            mem_stall, hazard;

    // A load still in EX or MEM has no data yet: it blocks forwarding and raises the stall instead.
    function automatic logic [1:0] fwd_sel(input logic [3:0] r, input logic u);
        logic ex_hit, mem_hit, wb_hit;
        ex_hit  = ex_rf_e && ex_dst == r;
        mem_hit = mem_rf_e && mem_dst == r;
        wb_hit  = wb_rf_e && wb_dst == r;
        return (!u || r == 4'd15) ? 2'b00 :
               ex_hit  ? (ex_load  ? 2'b00 : 2'b01) :
               mem_hit ? (mem_load ? 2'b00 : 2'b10) :
               wb_hit  ? 2'b11 : 2'b00;
    endfunction

    function automatic logic load_use(input logic [3:0] r, input logic u);
        return u && ((ex_rf_e && ex_load && ex_dst == r) || (mem_rf_e && mem_load && mem_dst == r));
    endfunction

    assign mem_stall   = mem_e && !mem_ready;
    assign pipe_hold   = reset && (state == MEM_WAIT || mem_stall);
    assign hazard      = reset && state == RUN &&
                         (load_use(id_rn, id_use_rn) || load_use(id_rm, id_use_rm) || load_use(id_rd, id_use_rd));
    assign pc_e        = !pipe_hold && !hazard;
    assign if_id_e     = !pipe_hold && !hazard;
    assign nop_sel     = !pipe_hold && hazard;
    assign if_id_flush = reset && !pipe_hold && !hazard && id_b_taken;
    assign fwd_a       = fwd_sel(id_rn, id_use_rn);
    assign fwd_b       = fwd_sel(id_rm, id_use_rm);
    assign fwd_c       = fwd_sel(id_rd, id_use_rd);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= RUN;
            wcnt    <= '0;
            mem_err <= 1'b0;
        end else if (state == RUN) begin
            if (mem_stall) begin
                state <= MEM_WAIT;
                wcnt  <= WC_W'(1);
            end
        end else if (mem_ready) begin
            state <= RUN;
            wcnt  <= '0;
        end else if (wcnt == WC_W'(MEM_TIMEOUT)) begin
            state   <= RUN;
            wcnt    <= '0;
            mem_err <= 1'b1;
        end else begin
            wcnt <= wcnt + WC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {ex_dst, ex_rf_e, ex_load}    <= '0;
            {mem_dst, mem_rf_e, mem_load} <= '0;
            {wb_dst, wb_rf_e}             <= '0;
        end else if (!pipe_hold) begin
            ex_dst   <= nop_sel ? 4'd0 : id_dst;
            ex_rf_e  <= !nop_sel && id_rf_e;
            ex_load  <= !nop_sel && id_load;
            mem_dst  <= ex_dst;
            mem_rf_e <= ex_rf_e;
            mem_load <= ex_load;
            wb_dst   <= mem_dst;
            wb_rf_e  <= mem_rf_e;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            wait_cnt  <= '0;
        end else begin
            if (nop_sel && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
            if (if_id_flush && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
            if (pipe_hold && wait_cnt != '1) wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
    assign wait_cnt  = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scoreboard bench with an in-flight instruction queue as the reference model.
module tb_pipeline_hazard_ctrl;
    localparam int TO = 6;
    localparam int CW = 16;

    logic clk = 1'b0, reset = 1'b0;
    logic [3:0] id_rn = '0, id_rm = '0, id_rd = '0, id_dst = '0;
    logic id_use_rn = 0, id_use_rm = 0, id_use_rd = 0, id_rf_e = 0, id_load = 0, id_b_taken = 0;
    logic mem_e = 0, mem_ready = 1;
    logic pc_e, if_id_e, if_id_flush, nop_sel, pipe_hold, mem_err;
    logic [1:0] fwd_a, fwd_b, fwd_c;
    logic [CW-1:0] stall_cnt, flush_cnt, wait_cnt;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
        .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_use_rd(id_use_rd),
        .id_dst(id_dst), .id_rf_e(id_rf_e), .id_load(id_load), .id_b_taken(id_b_taken),
        .mem_e(mem_e), .mem_ready(mem_ready),
        .pc_e(pc_e), .if_id_e(if_id_e), .if_id_flush(if_id_flush), .nop_sel(nop_sel),
        .pipe_hold(pipe_hold), .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_c(fwd_c), .mem_err(mem_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
    );

    typedef struct {
        logic pc_e, if_id_e, flush, nop, hold, err;
        logic [1:0] fa, fb, fc;
        logic [CW-1:0] sc, fl, wc;
    } exp_t;
    typedef struct {logic [3:0] dst; logic wr; logic load;} slot_t;

    exp_t  q[$];
    slot_t flight[$];
    int compared = 0, mismatched = 0;
    bit in_wait, err;
    int waited, n_stall, n_flush, n_wait;

    // flight[0] is the youngest issued instruction (EX), flight[2] the oldest tracked (WB).
    function automatic logic [1:0] m_fwd(input logic [3:0] r, input logic u);
        if (!u || r == 4'd15) return 2'b00;
        for (int k = 0; k < 3; k++)
            if (flight[k].wr && flight[k].dst == r) return (flight[k].load && k < 2) ? 2'b00 : 2'(k + 1);
        return 2'b00;
    endfunction

    function automatic bit m_lu(input logic [3:0] r, input logic u);
        bit h = 0;
        for (int k = 0; k < 2; k++) h |= u && flight[k].wr && flight[k].load && flight[k].dst == r;
        return h;
    endfunction

    task automatic model_clear();
        flight = {};
        repeat (3) flight.push_back('{dst: 4'd0, wr: 1'b0, load: 1'b0});
        in_wait = 0; err = 0; waited = 0; n_stall = 0; n_flush = 0; n_wait = 0;
    endtask

    task automatic step(input bit rn_ok, input logic [3:0] rn, rm, rd, input logic urn, urm, urd,
                        input logic [3:0] dst, input logic rfe, ld, bt, me, mr);
        exp_t e;
        bit hold, haz;
        @(posedge clk); #1;
        reset = rn_ok; id_rn = rn; id_rm = rm; id_rd = rd;
        id_use_rn = urn; id_use_rm = urm; id_use_rd = urd;
        id_dst = dst; id_rf_e = rfe; id_load = ld; id_b_taken = bt; mem_e = me; mem_ready = mr;
        if (!rn_ok) model_clear();
        hold = rn_ok && (in_wait || (me && !mr));
        haz  = rn_ok && !in_wait && (m_lu(rn, urn) || m_lu(rm, urm) || m_lu(rd, urd));
        e.hold = hold; e.nop = !hold && haz; e.pc_e = !hold && !haz; e.if_id_e = !hold && !haz;
        e.flush = rn_ok && !hold && !haz && bt;
        e.fa = m_fwd(rn, urn); e.fb = m_fwd(rm, urm); e.fc = m_fwd(rd, urd);
        e.err = err;
`ifdef HAZARD_PERF_CNT_EN
        e.sc = CW'(n_stall); e.fl = CW'(n_flush); e.wc = CW'(n_wait);
`else
        e.sc = '0; e.fl = '0; e.wc = '0;
`endif
        q.push_back(e);
        if (rn_ok) begin
            if (e.nop && n_stall < (1 << CW) - 1) n_stall++;
            if (e.flush && n_flush < (1 << CW) - 1) n_flush++;
            if (hold && n_wait < (1 << CW) - 1) n_wait++;
            if (!hold) begin
                flight.push_front(e.nop ? '{dst: 4'd0, wr: 1'b0, load: 1'b0} : '{dst: dst, wr: rfe, load: ld});
                void'(flight.pop_back());
            end
            // A wait ends on ready or once TO cycles have been spent waiting; the first stalled RUN cycle counts as 0.
            if (!in_wait) begin
                if (me && !mr) begin in_wait = 1; waited = 1; end
            end else if (mr) in_wait = 0;
            else if (waited == TO) begin err = 1; in_wait = 0; end
            else waited++;
        end
    endtask

    task automatic issue(input logic [3:0] rn, rm, rd, input logic urn, urm, urd,
                         input logic [3:0] dst, input logic rfe, ld, bt);
        step(1, rn, rm, rd, urn, urm, urd, dst, rfe, ld, bt, 1'b0, 1'b1);
    endtask

    task automatic mw(input logic me, mr);
        step(1, 4'd1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b0, 4'd9, 1'b1, 1'b0, 1'b0, me, mr);
    endtask

    task automatic chk(input string nm, input logic [CW-1:0] act, exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("pc_e", CW'(pc_e), CW'(e.pc_e));
            chk("if_id_e", CW'(if_id_e), CW'(e.if_id_e));
            chk("if_id_flush", CW'(if_id_flush), CW'(e.flush));
            chk("nop_sel", CW'(nop_sel), CW'(e.nop));
            chk("pipe_hold", CW'(pipe_hold), CW'(e.hold));
            chk("mem_err", CW'(mem_err), CW'(e.err));
            chk("fwd_a", CW'(fwd_a), CW'(e.fa));
            chk("fwd_b", CW'(fwd_b), CW'(e.fb));
            chk("fwd_c", CW'(fwd_c), CW'(e.fc));
            chk("stall_cnt", stall_cnt, e.sc);
            chk("flush_cnt", flush_cnt, e.fl);
            chk("wait_cnt", wait_cnt, e.wc);
        end
    end

    function automatic logic [3:0] rreg();
        return ($urandom % 8 == 0) ? 4'd15 : 4'($urandom % 4);
    endfunction

    initial begin
        model_clear();
        // reset forces outputs even with a stalled memory and a taken branch
        step(0, 4'd1, 4'd1, 4'd1, 1, 1, 1, 4'd1, 1, 1, 1, 1, 0);
        step(0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 1);
        // ALU result forwarded from EX, then MEM, then WB
        issue(4'd0, 4'd0, 4'd0, 0, 0, 0, 4'd3, 1, 0, 0);
        issue(4'd3, 4'd0, 4'd0, 1, 0, 0, 4'd5, 0, 0, 0);
        issue(4'd3, 4'd0, 4'd0, 1, 0, 0, 4'd5, 0, 0, 0);
        issue(4'd3, 4'd0, 4'd0, 1, 0, 0, 4'd5, 0, 0, 0);
        // r15 never forwarded
        issue(4'd0, 4'd0, 4'd0, 0, 0, 0, 4'd15, 1, 0, 0);
        issue(4'd15, 4'd15, 4'd15, 1, 1, 1, 4'd0, 0, 0, 0);
        // load-use: two bubbles then WB forward
        issue(4'd0, 4'd0, 4'd0, 0, 0, 0, 4'd2, 1, 1, 0);
        repeat (3) issue(4'd0, 4'd2, 4'd0, 0, 1, 0, 4'd6, 1, 0, 0);
        // branch alone, then branch colliding with a load-use stall
        issue(4'd0, 4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 1);
        issue(4'd0, 4'd0, 4'd0, 0, 0, 0, 4'd4, 1, 1, 0);
        repeat (3) issue(4'd4, 4'd0, 4'd0, 1, 0, 0, 4'd0, 0, 0, 1);
        // memory wait ended by ready
        issue(4'd0, 4'd0, 4'd0, 0, 0, 0, 4'd7, 1, 0, 0);
        repeat (5) mw(1, 0);
        mw(1, 1);
        repeat (3) mw(0, 1);
        // memory timeout, sticky error, cleared by reset
        repeat (TO + 1) mw(1, 0);
        repeat (3) mw(0, 1);
        step(0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 1);
        repeat (2) mw(0, 1);
        // randomized traffic including occasional resets mid-wait
        repeat (3000)
            step(($urandom % 300) != 0, rreg(), rreg(), rreg(), 1'($urandom), 1'($urandom), 1'($urandom),
                 rreg(), 1'($urandom), ($urandom % 4) == 0, ($urandom % 6) == 0,
                 ($urandom % 5) == 0, ($urandom % 3) != 0);
        repeat (2) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            compared++; mismatched++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
